slurm32_instruction_cache: RTL and testbench



---
 rtl/slurm32_instruction_cache_pkg.sv | 21 ++
 rtl/slurm32_instruction_cache_sync_ram.sv | 24 ++
 rtl/slurm32_instruction_cache.sv | 143 ++++++++++++++
 tb/tb_slurm32_instruction_cache.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slurm32_instruction_cache_pkg.sv
// Shared definitions for the slurm32 instruction cache: state encoding,
// the idle/reset instruction word and address-field helpers.
package slurm32_instruction_cache_pkg;

  typedef enum logic [1:0] {
    st_lookup = 2'd0,
    st_refill = 2'd1,
    st_resume = 2'd2
  } cache_state_t;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

  // Byte-within-word bits sit below the word offset.
  localparam int OFFSET_LSB = 2;

  function automatic int tag_width(input int address_bits, input int line_bits,
                                   input int word_bits);
    return address_bits - line_bits - word_bits - OFFSET_LSB;
  endfunction

endpackage

// File: rtl/slurm32_instruction_cache_sync_ram.sv
// Single write port / single read port RAM with a registered read,
// used for both the instruction words and the line tags.
module slurm32_instruction_cache_sync_ram #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/slurm32_instruction_cache.sv
// Direct-mapped read-only instruction cache: one-cycle lookup for the fetch
// port, four-beat line refill from the memory bus on a miss.
module slurm32_instruction_cache
  import slurm32_instruction_cache_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int LINE_BITS    = 6,
  parameter int WORD_BITS    = 2
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    instruction_request,
  input  logic [ADDRESS_BITS-1:0] instruction_address,
  output logic                    instruction_valid,
  output logic [BITS-1:0]         instruction_in,
  input  logic                    invalidate,
  output logic                    mem_request,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic                    mem_ready,
  input  logic [BITS-1:0]         mem_data,
  output logic                    busy
);

  localparam int TAG_BITS = tag_width(ADDRESS_BITS, LINE_BITS, WORD_BITS);
  localparam int LINES    = 1 << LINE_BITS;
  localparam int OFF_LSB  = OFFSET_LSB;
  localparam int IDX_LSB  = WORD_BITS + OFFSET_LSB;
  localparam int TAG_LSB  = LINE_BITS + WORD_BITS + OFFSET_LSB;

  cache_state_t state, state_next;

  logic                 req_p1;
  logic [TAG_BITS-1:0]  tag_p1;
  logic [LINE_BITS-1:0] index_p1;
  logic [WORD_BITS-1:0] beat;
  logic                 inv_pending;
  logic [LINES-1:0]     valid;

  logic [BITS-1:0]      data_rdata;
  logic [TAG_BITS-1:0]  tag_rdata;

  logic [TAG_BITS-1:0]  req_tag;
  logic [LINE_BITS-1:0] req_index;
  logic [WORD_BITS-1:0] req_offset;

  logic hit, miss, accept, beat_done, last_beat;
  logic unused_addr_bits;

  assign req_tag    = instruction_address[ADDRESS_BITS-1:TAG_LSB];
  assign req_index  = instruction_address[TAG_LSB-1:IDX_LSB];
  assign req_offset = instruction_address[IDX_LSB-1:OFF_LSB];
  assign unused_addr_bits = ^instruction_address[OFF_LSB-1:0];

  assign hit       = req_p1 & valid[index_p1] & (tag_rdata == tag_p1);
  assign miss      = req_p1 & ~hit;
  // New fetches are only taken while looking up and not stalling on a miss.
  assign accept    = (state == st_lookup) & ~miss;
  assign beat_done = (state == st_refill) & mem_ready;
  assign last_beat = beat_done & (beat == '1);

  always_comb begin
    state_next = state;
    case (state)
      st_lookup: if (miss) state_next = st_refill;
      st_refill: if (last_beat) state_next = st_resume;
      st_resume: state_next = st_lookup;
      default:   state_next = st_lookup;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state       <= st_lookup;
      req_p1      <= 1'b0;
      beat        <= '0;
      inv_pending <= 1'b0;
      valid       <= '0;
    end else begin
      state  <= state_next;
      req_p1 <= accept & instruction_request;
      if ((state == st_lookup) && miss) begin
        beat <= '0;
      end else if (beat_done) begin
        beat <= beat + 1'b1;
      end
      if (state == st_refill) begin
        if (last_beat) begin
          inv_pending <= 1'b0;
          // An invalidate seen at any point of the refill keeps the new line out.
          if (inv_pending || invalidate) begin
            valid <= '0;
          end else begin
            valid[index_p1] <= 1'b1;
          end
        end else if (invalidate) begin
          inv_pending <= 1'b1;
        end
      end else if (invalidate) begin
        valid <= '0;
      end
    end
  end

  // Stage p0 -> p1: lookup address held for the tag compare and any refill.
  always_ff @(posedge CLK) begin
    if (accept) begin
      tag_p1   <= req_tag;
      index_p1 <= req_index;
    end
  end

  slurm32_instruction_cache_sync_ram #(
    .WIDTH      (BITS),
    .DEPTH_BITS (LINE_BITS + WORD_BITS)
  ) u_data_ram (
    .clk   (CLK),
    .we    (beat_done),
    .waddr ({index_p1, beat}),
    .wdata (mem_data),
    .raddr ({req_index, req_offset}),
    .rdata (data_rdata)
  );

  slurm32_instruction_cache_sync_ram #(
    .WIDTH      (TAG_BITS),
    .DEPTH_BITS (LINE_BITS)
  ) u_tag_ram (
    .clk   (CLK),
    .we    (last_beat),
    .waddr (index_p1),
    .wdata (tag_p1),
    .raddr (req_index),
    .rdata (tag_rdata)
  );

  assign instruction_valid = hit;
  assign instruction_in    = hit ? data_rdata : BITS'(NOP_INSTRUCTION);
  assign mem_request       = (state == st_refill);
  assign mem_address       = mem_request ? {tag_p1, index_p1, beat, 2'b00} : '0;
  assign busy              = (state != st_lookup);

endmodule

// File: tb/tb_slurm32_instruction_cache.sv
// Self-checking bench for slurm32_instruction_cache: directed scenarios plus
// randomized fetch/invalidate traffic against a line-level cache model.
module tb_slurm32_instruction_cache;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic        instruction_request = 1'b0;
  logic [31:0] instruction_address = 32'h0;
  logic        instruction_valid;
  logic [31:0] instruction_in;
  logic        invalidate = 1'b0;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int mem_delay = 0;
  int req_cycles = 0;
  logic [31:0] beat_log[$];

  slurm32_instruction_cache dut (
    .CLK                 (CLK),
    .RSTb                (RSTb),
    .instruction_request (instruction_request),
    .instruction_address (instruction_address),
    .instruction_valid   (instruction_valid),
    .instruction_in      (instruction_in),
    .invalidate          (invalidate),
    .mem_request         (mem_request),
    .mem_address         (mem_address),
    .mem_ready           (mem_ready),
    .mem_data            (mem_data),
    .busy                (busy)
  );

  initial forever #5 CLK = ~CLK;

  // Backing memory contents; the first line at 0x100 holds 0xA0..0xA3.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + {30'd0, a[3:2]};
    return {a[15:2], 2'b01, ~a[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: which lines hold which tag, plus refill progress.
  bit          m_valid[64];
  logic [21:0] m_tag[64];
  int          phase = 0;   // 0 answering fetches, 1 refilling, 2 one-cycle bubble
  int          beats = 0;
  logic [31:0] rf_base = 32'h0;
  bit          inv_pend = 0;
  bit          cur_req = 0;
  logic [31:0] cur_addr = 32'h0;
  bit          cur_hit = 0;

  task automatic clear_lines();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
  endtask

  initial begin
    clear_lines();
    forever begin
      @(posedge CLK);
      if (!RSTb) begin
        clear_lines();
        phase = 0; beats = 0; inv_pend = 0; cur_req = 0; cur_hit = 0;
      end else begin
        bit nreq;
        logic [31:0] naddr;
        nreq = 0;
        naddr = cur_addr;
        case (phase)
          0: begin
            if (cur_req && !cur_hit) begin
              phase = 1; beats = 0; rf_base = {cur_addr[31:4], 4'h0};
            end else begin
              nreq = instruction_request; naddr = instruction_address;
            end
            if (invalidate) clear_lines();
          end
          1: begin
            if (mem_ready && beats == 3) begin
              if (inv_pend || invalidate) clear_lines();
              else begin
                m_valid[rf_base[9:4]] = 1;
                m_tag[rf_base[9:4]] = rf_base[31:10];
              end
              inv_pend = 0; beats = 0; phase = 2;
            end else begin
              if (mem_ready) beats++;
              if (invalidate) inv_pend = 1;
            end
          end
          default: begin
            phase = 0;
            if (invalidate) clear_lines();
          end
        endcase
        cur_req = nreq;
        cur_addr = naddr;
        cur_hit = cur_req && m_valid[cur_addr[9:4]] && (m_tag[cur_addr[9:4]] == cur_addr[31:10]);
      end
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (mem_request && mem_ready) beat_log.push_back(mem_address);
    if (mem_request) req_cycles++;
    if (chk_en) begin
      logic [31:0] e_in, e_ma;
      bit e_iv, e_mr, e_busy;
      if (!RSTb) begin
        e_iv = 0; e_in = 0; e_mr = 0; e_ma = 0; e_busy = 0;
      end else begin
        e_iv = cur_hit;
        e_in = cur_hit ? memword({cur_addr[31:2], 2'b00}) : 32'h0;
        e_mr = (phase == 1);
        e_ma = (phase == 1) ? rf_base + 32'(beats * 4) : 32'h0;
        e_busy = (phase != 0);
      end
      chk("cyc_ivalid", {31'd0, instruction_valid}, {31'd0, e_iv});
      chk("cyc_instr", instruction_in, e_in);
      chk("cyc_mreq", {31'd0, mem_request}, {31'd0, e_mr});
      chk("cyc_maddr", mem_address, e_ma);
      chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
    end
  end

  // Memory responder: acknowledges each beat after mem_delay waiting cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem_request && RSTb) begin
        if (cnt >= mem_delay) begin
          mem_ready = 1'b1; mem_data = memword(mem_address); cnt = 0;
        end else begin
          mem_ready = 1'b0; cnt++;
        end
      end else begin
        mem_ready = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [31:0] a);
    instruction_request = 1'b1;
    instruction_address = a;
    tick();
    instruction_request = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!busy) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 300; i++) begin
      if (beat_log.size() >= n) return;
      tick();
    end
    chk("wait_beats_timeout", beat_log.size(), n);
  endtask

  task automatic clear_log();
    beat_log.delete();
    req_cycles = 0;
  endtask

  initial begin
    #1 RSTb = 1'b0;
    #1 chk_en = 1;
    tick(); tick();
    chk("reset_ivalid", {31'd0, instruction_valid}, 32'd0);
    chk("reset_instr", instruction_in, 32'h0);
    chk("reset_mreq", {31'd0, mem_request}, 32'd0);
    chk("reset_maddr", mem_address, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    RSTb = 1'b1;
    tick();

    // Cold miss and refill of line 0x100
    clear_log();
    present(32'h100);
    chk("cold_miss_valid", {31'd0, instruction_valid}, 32'd0);
    wait_idle();
    chk("cold_beats", beat_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("cold_beat_addr", beat_log[i], 32'h100 + 32'(i * 4));
    present(32'h100);
    chk("cold_hit_valid", {31'd0, instruction_valid}, 32'd1);
    chk("cold_hit_data", instruction_in, 32'hA0);

    // Streaming hits
    instruction_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction_address = 32'h100 + 32'(i * 4);
      tick();
      chk("stream_valid", {31'd0, instruction_valid}, 32'd1);
      chk("stream_data", instruction_in, 32'hA0 + 32'(i));
    end
    instruction_request = 1'b0;
    tick();

    // Conflict miss on the same index
    clear_log();
    present(32'h1100);
    chk("conflict_miss", {31'd0, instruction_valid}, 32'd0);
    wait_beats(1);
    chk("conflict_first_beat", beat_log[0], 32'h1100);
    wait_idle();
    present(32'h1100);
    chk("conflict_hit", {31'd0, instruction_valid}, 32'd1);
    present(32'h100);
    chk("conflict_evicted", {31'd0, instruction_valid}, 32'd0);
    wait_idle();

    // Invalidate together with a lookup
    instruction_request = 1'b1; instruction_address = 32'h104; invalidate = 1'b1;
    tick();
    instruction_request = 1'b0; invalidate = 1'b0;
    chk("inv_same_cycle_miss", {31'd0, instruction_valid}, 32'd0);
    wait_idle();

    // Invalidate during beat 1 of a refill
    mem_delay = 2;
    clear_log();
    present(32'h200);
    wait_beats(1);
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    wait_idle();
    clear_log();
    present(32'h200);
    chk("inv_refill_miss", {31'd0, instruction_valid}, 32'd0);
    wait_beats(1);
    chk("inv_refill_restart", beat_log[0], 32'h200);
    wait_idle();

    // Slow memory
    mem_delay = 5;
    clear_log();
    present(32'h300);
    wait_idle();
    chk("slow_beats", beat_log.size(), 4);
    chk("slow_req_cycles", req_cycles, 24);
    chk("slow_last_addr", beat_log[3], 32'h30C);
    present(32'h30C);
    chk("slow_hit_data", instruction_in, 32'h030DFF3C);

    // Top of the address space
    mem_delay = 0;
    present(32'hFFFFFFFC);
    wait_idle();
    present(32'hFFFFFFFC);
    chk("wrap_hit", {31'd0, instruction_valid}, 32'd1);

    // Reset in the middle of a refill
    mem_delay = 3;
    clear_log();
    present(32'h100);
    wait_beats(2);
    #2 RSTb = 1'b0;
    #1;
    chk("rst_mid_mreq", {31'd0, mem_request}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    RSTb = 1'b1;
    tick();
    present(32'h100);
    chk("rst_after_miss", {31'd0, instruction_valid}, 32'd0);
    wait_idle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [21:0] t;
      logic [5:0]  ix;
      case ($urandom_range(0, 2))
        0: t = 22'h0;
        1: t = 22'h1;
        default: t = 22'h3FFFFF;
      endcase
      case ($urandom_range(0, 3))
        0: ix = 6'h00;
        1: ix = 6'h10;
        2: ix = 6'h3F;
        default: ix = 6'h05;
      endcase
      if (c % 50 == 0) mem_delay = $urandom_range(0, 3);
      instruction_request = ($urandom_range(0, 3) != 0);
      instruction_address = {t, ix, 4'($urandom_range(0, 15))};
      invalidate = ($urandom_range(0, 39) == 0);
      tick();
    end
    instruction_request = 1'b0;
    invalidate = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
